cond_logic: RTL

//  Consumer of the ALU status output: latches ALUFlag {N,Z,C,V} into an architectural

---
 rtl/cond_logic.sv | 104 ++++++++++
 1 files changed

// File: rtl/cond_logic.sv
// ---------------------------------------------------------------------------
// cond_logic
//   Holds the architectural condition flags {N,Z,C,V} of the ARM32 core. It
//   checks the 4-bit condition field of the current instruction against those
//   stored flags. When the condition fails, the instruction becomes a no-op:
//   the PC, register-file and memory write strobes are suppressed, and the
//   flags are left untouched.
//
// Parameters
//   FLAG_RST   reset value of the stored {N,Z,C,V}
//   NV_EXEC    behaviour of condition 4'b1111 (0 = never, 1 = always)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   Cond       instruction condition field Instr[31:28]
//   ALUFlag    {N,Z,C,V} produced by the ALU for the current instruction
//   FlagW      [1] update N,Z ; [0] update C,V
//   PCS        decoder: instruction writes PC
//   RegW       decoder: instruction writes register file
//   MemW       decoder: instruction writes memory
//   Stall      hold: no flag update and no writes this cycle
//   CondEx     condition passes against the stored flags (combinational)
//   PCSrc      PCS  & CondEx & ~Stall
//   RegWrite   RegW & CondEx & ~Stall
//   MemWrite   MemW & CondEx & ~Stall
//   Flags      stored {N,Z,C,V}
// ---------------------------------------------------------------------------
module cond_logic #(
   parameter logic [3:0] FLAG_RST = 4'b0000,
   parameter bit         NV_EXEC  = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlag,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       Stall,
   output logic       CondEx,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags
);

   logic [3:0] flags_q;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       go;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // The condition is evaluated against the stored flags only. The ALU result
   // of the current instruction is not bypassed, so a flag-setting instruction
   // affects the next instruction onward.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         4'b0000: CondEx = flag_z;
         4'b0001: CondEx = ~flag_z;
         4'b0010: CondEx = flag_c;
         4'b0011: CondEx = ~flag_c;
         4'b0100: CondEx = flag_n;
         4'b0101: CondEx = ~flag_n;
         4'b0110: CondEx = flag_v;
         4'b0111: CondEx = ~flag_v;
         4'b1000: CondEx = flag_c & ~flag_z;
         4'b1001: CondEx = ~flag_c | flag_z;
         4'b1010: CondEx = (flag_n == flag_v);
         4'b1011: CondEx = (flag_n != flag_v);
         4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
         4'b1101: CondEx = flag_z | (flag_n != flag_v);
         4'b1110: CondEx = 1'b1;
         4'b1111: CondEx = NV_EXEC;
         default: CondEx = 1'b0;
      endcase
   end

   // Stall masks all side effects. Because Stall is ANDed in here, an unknown
   // Cond during a stall still produces a clean 0 enable for the flag register.
   assign go       = CondEx & ~Stall;
   assign PCSrc    = PCS  & go;
   assign RegWrite = RegW & go;
   assign MemWrite = MemW & go;

   // N,Z and C,V are written independently. A half that is not selected keeps
   // its previous value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= FLAG_RST;
      end else if (go) begin
         if (FlagW[1]) flags_q[3:2] <= ALUFlag[3:2];
         if (FlagW[0]) flags_q[1:0] <= ALUFlag[1:0];
      end
   end

   assign Flags = flags_q;

endmodule
